// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver with mid-bit sampling and mid-stop-bit re-arm.
// Optional macro UART_RECV_FRAME_CHK_EN: a low stop bit raises frame_err instead of delivering the byte.
module uart_recv #(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    output logic       uart_done,
    output logic [7:0] uart_data,
    output logic       frame_err
);
    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam logic [15:0] CNT_MAX = 16'(BPS_CNT - 1);
    localparam logic [15:0] CNT_MID = 16'(BPS_CNT / 2);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t      state_q, state_d;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        rxd_s1_q, rxd_s2_q, rxd_s3_q;
    logic        start_flag, mid, wrap;

    assign start_flag = rxd_s3_q & ~rxd_s2_q;
    assign mid        = clk_cnt_q == CNT_MID;
    assign wrap       = clk_cnt_q == CNT_MAX;
    assign uart_done  = done_q;
    assign uart_data  = data_q;

    // Synchronize the line and keep one extra stage for falling-edge detection; reset to idle-high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1_q <= 1'b1;
            rxd_s2_q <= 1'b1;
            rxd_s3_q <= 1'b1;
        end else begin
            rxd_s1_q <= uart_rxd;
            rxd_s2_q <= rxd_s1_q;
            rxd_s3_q <= rxd_s2_q;
        end
    end

    // Receiver state, counters, shift register and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clk_cnt_q <= 16'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
        end
    end

`ifdef UART_RECV_FRAME_CHK_EN
    logic ferr_q, ferr_d;
    assign frame_err = ferr_q;

    // Frame-error pulse register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ferr_q <= 1'b0;
        else        ferr_q <= ferr_d;
    end
`else
    assign frame_err = 1'b0;
`endif

    // Next-state logic: bit timing, start validation, data capture and stop handling
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = 16'd0;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
`ifdef UART_RECV_FRAME_CHK_EN
        ferr_d    = 1'b0;
`endif
        case (state_q)
            IDLE: state_d = start_flag ? START : IDLE;
            START: begin
                clk_cnt_d = wrap ? 16'd0 : clk_cnt_q + 16'd1;
                if (mid && rxd_s2_q) begin
                    state_d   = IDLE;
                    clk_cnt_d = 16'd0;
                end else if (wrap) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                clk_cnt_d = wrap ? 16'd0 : clk_cnt_q + 16'd1;
                if (mid) shift_d[bit_cnt_q] = rxd_s2_q;
                if (wrap) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    state_d   = (bit_cnt_q == 3'd7) ? STOP : DATA;
                end
            end
            STOP: begin
                clk_cnt_d = clk_cnt_q + 16'd1;
                if (mid) begin
                    clk_cnt_d = 16'd0;
                    state_d   = rxd_s2_q ? IDLE : WAIT_HIGH;
`ifdef UART_RECV_FRAME_CHK_EN
                    done_d    = rxd_s2_q;
                    data_d    = rxd_s2_q ? shift_q : data_q;
                    ferr_d    = ~rxd_s2_q;
`else
                    done_d    = 1'b1;
                    data_d    = shift_q;
`endif
                end
            end
            WAIT_HIGH: state_d = rxd_s2_q ? IDLE : WAIT_HIGH;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: table-driven checks of uart_recv at BPS_CNT = 10, plus glitch and mid-frame reset sequences.
module tb_uart_recv;
    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         gap;
        logic       glitch;
        logic       exp_done;
        logic       exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       uart_rxd = 1'b1;
    logic       uart_done, frame_err;
    logic [7:0] uart_data;
    logic [7:0] prev_data = 8'h00;
    int checks = 0, errors = 0, cyc = 0, start_cyc = 0;
    int done_cnt = 0, ferr_cnt = 0, done_cyc = 0, both_cnt = 0, bad_chg = 0;

    uart_recv #(.CLK_FREQ(1000000), .UART_BPS(100000)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_rxd (uart_rxd),
        .uart_done(uart_done),
        .uart_data(uart_data),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counting and output-stability monitoring, sampled on the falling edge
    always @(negedge clk) begin
        if (uart_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (frame_err) ferr_cnt++;
        if (uart_done && frame_err) both_cnt++;
        if (rst_n && !uart_done && uart_data !== prev_data) bad_chg++;
        prev_data = uart_data;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_lat(input string name);
        int lat;
        lat = done_cyc - start_cyc;
        checks++;
        if (lat < 97 || lat > 99) begin
            errors++;
            $display("FAIL %s latency: got %0d expected 97..99", name, lat);
        end
    endtask

    task automatic drive_bit(input logic b);
        uart_rxd = b;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int k = 0; k < 8; k++) drive_bit(d[k]);
        drive_bit(stop);
        uart_rxd = 1'b1;
    endtask

    initial begin
        vec_t v[5];
        int d0, f0;
        logic [7:0] vb;
        v[0] = '{8'hA5, 1'b1, 20, 1'b0, 1'b1, 1'b0, 8'hA5};
        v[1] = '{8'h00, 1'b1, 0,  1'b0, 1'b1, 1'b0, 8'h00};
        v[2] = '{8'hFF, 1'b1, 20, 1'b0, 1'b1, 1'b0, 8'hFF};
        v[3] = '{8'h3C, 1'b1, 20, 1'b1, 1'b1, 1'b0, 8'h3C};
`ifdef UART_RECV_FRAME_CHK_EN
        v[4] = '{8'h55, 1'b0, 20, 1'b0, 1'b0, 1'b1, 8'h3C};
`else
        v[4] = '{8'h55, 1'b0, 20, 1'b0, 1'b1, 1'b0, 8'h55};
`endif
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset data", int'(uart_data), 8'h00);
        chk("reset done", int'(uart_done), 0);
        chk("reset ferr", int'(frame_err), 0);
        rst_n = 1'b1;
        repeat (500) @(posedge clk);
        #1;
        chk("idle done", done_cnt, 0);
        chk("idle ferr", ferr_cnt, 0);
        chk("idle data", int'(uart_data), 8'h00);
        for (int i = 0; i < 5; i++) begin
            if (v[i].glitch) begin
                d0 = done_cnt;
                uart_rxd = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                uart_rxd = 1'b1;
                repeat (30) @(posedge clk);
                #1;
                chk("glitch done", done_cnt - d0, 0);
            end
            d0 = done_cnt;
            f0 = ferr_cnt;
            send_frame(v[i].d, v[i].stop);
            repeat (v[i].gap) @(posedge clk);
            #1;
            chk($sformatf("vec%0d done", i), done_cnt - d0, int'(v[i].exp_done));
            chk($sformatf("vec%0d ferr", i), ferr_cnt - f0, int'(v[i].exp_ferr));
            chk($sformatf("vec%0d data", i), int'(uart_data), int'(v[i].exp_data));
            if (v[i].exp_done) chk_lat($sformatf("vec%0d", i));
        end
        d0 = done_cnt;
        vb = 8'hC3;
        drive_bit(1'b0);
        for (int k = 0; k < 4; k++) drive_bit(vb[k]);
        uart_rxd = vb[4];
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midreset data", int'(uart_data), 8'h00);
        chk("midreset done", int'(uart_done), 0);
        chk("midreset ferr", int'(frame_err), 0);
        @(posedge clk);
        #1;
        repeat (4) @(posedge clk);
        #1;
        for (int k = 5; k < 8; k++) drive_bit(vb[k]);
        drive_bit(1'b1);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("aborted frame done", done_cnt - d0, 0);
        chk("aborted frame data", int'(uart_data), 8'h00);
        d0 = done_cnt;
        send_frame(8'h81, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        chk("after reset done", done_cnt - d0, 1);
        chk("after reset data", int'(uart_data), 8'h81);
        chk_lat("after reset");
        chk("done with ferr", both_cnt, 0);
        chk("data change without done", bad_chg, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_recv.md
UART_RECV -- requirements
Module: uart_recv

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz, SHALL be provided.
REQ-002 Parameter UART_BPS, default 9600, serial baud rate, SHALL be provided; BPS_CNT = CLK_FREQ/UART_BPS (integer), legal range 4..65535.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 uart_rxd  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 uart_done  output  1  one-cycle pulse, valid byte on uart_data.
REQ-007 uart_data  output  8  last received byte, held until next valid byte.
REQ-008 frame_err  output  1  one-cycle pulse on bad stop bit (see Configuration).

Function
REQ-009 uart_rxd SHALL pass through a 2-flop synchronizer (rxd_s1, rxd_s2) plus one delay flop (rxd_s3); start_flag = rxd_s3 & ~rxd_s2.
REQ-010 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH; 16-bit clk_cnt counts 0..BPS_CNT-1 and wraps; 3-bit bit_cnt indexes data bits.
REQ-011 IDLE: start_flag high -> START with clk_cnt=0; otherwise remain, clk_cnt held 0.
REQ-012 Sample point SHALL be clk_cnt == BPS_CNT/2 in every bit period.
REQ-013 START: sample high -> false start, back to IDLE, no output activity; sample low -> continue; at clk_cnt wrap -> DATA, bit_cnt=0.
REQ-014 DATA: at sample point, rxd_s2 shifted into internal shift register bit position bit_cnt; at wrap bit_cnt increments; after bit 7 wrap -> STOP.
REQ-015 STOP: at sample point with rxd_s2 high -> uart_data <= shift register, uart_done = 1 for exactly one cycle, FSM -> IDLE same edge (mid-stop-bit re-arm, supports back-to-back frames).
REQ-016 STOP: at sample point with rxd_s2 low -> behaviour per REQ-023/REQ-024.
REQ-017 WAIT_HIGH: remain until rxd_s2 high, then IDLE; no start detected while in WAIT_HIGH.
REQ-018 Latency: uart_done SHALL assert 9*BPS_CNT + BPS_CNT/2 + 3 cycles (+/-1) after the start-bit falling edge of uart_rxd.
REQ-019 uart_data SHALL change only on the cycle uart_done asserts; uart_done and frame_err never assert together.
REQ-020 Line glitches shorter than BPS_CNT/2 cycles while IDLE SHALL be rejected by REQ-013.

Reset
REQ-021 On rst_n low, asynchronously: FSM=IDLE, clk_cnt=0, bit_cnt=0, shift register=0, uart_data=8'h00, uart_done=0, frame_err=0, rxd_s1/s2/s3=1 (no spurious start at release).
REQ-022 Reset mid-frame SHALL abort the frame; the next start is detected only on a fresh falling edge after release.

Configuration
REQ-023 With UART_RECV_FRAME_CHK_EN defined: low stop sample -> frame_err pulses one cycle, uart_done stays 0, uart_data unchanged, FSM -> WAIT_HIGH.
REQ-024 Without UART_RECV_FRAME_CHK_EN: stop bit not checked; uart_done pulses and uart_data updates as in REQ-015, FSM -> WAIT_HIGH if line low else IDLE; frame_err tied 0.

Verification (bench overrides CLK_FREQ=1000000, UART_BPS=100000, BPS_CNT=10)
REQ-025 Reset released, uart_rxd held high 500 cycles -> uart_done, frame_err stay 0, uart_data=8'h00.
REQ-026 Send frame 8'hA5 (bits 10 cycles each) -> single uart_done pulse 98 +/-1 cycles after start edge, uart_data=8'hA5.
REQ-027 Send 8'h00 then 8'hFF back-to-back (1-bit stop only) -> two uart_done pulses, values 8'h00 then 8'hFF.
REQ-028 4-cycle low glitch on idle line -> no uart_done; following frame 8'h3C received correctly.
REQ-029 Frame 8'h55 with stop bit low, then line high -> with macro: frame_err pulse, uart_data unchanged; without: uart_done pulse, uart_data=8'h55.
REQ-030 rst_n pulsed low during bit 4 of frame 8'hC3 -> outputs reset values, no uart_done for that frame; next frame 8'h81 received correctly.
